// File: rtl/intt_pkg.sv
// Shared constants and types for the inverse-NTT twiddle path.
package intt_pkg;

  localparam int DW = 23;
  localparam logic [DW-1:0] Q = 23'd8380417;
  localparam int N = 256;
  localparam int LOGN = 8;

  typedef logic [DW-1:0] tf_t;
  typedef logic [7:0]    idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/intt_tf_sequencer_tf_rom.sv
// Forward twiddle table: entry k holds zeta^brv(k) mod Q (zeta = 1753).
// Entry 0 is unused; the inverse walk stops at k=1.
module tf_rom
  import intt_pkg::*;
(
  input  idx_t tf_case,
  output tf_t  zeta
);

  localparam tf_t TF_TABLE [N] = '{
    0,       4808194, 3765607, 3761513, 5178923, 5496691, 5234739, 5178987,
    7778734, 3542485, 2682288, 2129892, 3764867, 7375178, 557458,  7159240,
    5010068, 4317364, 2663378, 6705802, 4855975, 7946292, 676590,  7044481,
    5152541, 1714295, 2453983, 1460718, 7737789, 4795319, 2815639, 2283733,
    3602218, 3182878, 2740543, 4793971, 5269599, 2101410, 3704823, 1159875,
    394148,  928749,  1095468, 4874037, 2071829, 4361428, 3241972, 2156050,
    3415069, 1759347, 7562881, 4805951, 3756790, 6444618, 6663429, 4430364,
    5483103, 3192354, 556856,  3870317, 2917338, 1853806, 3345963, 1858416,
    3073009, 1277625, 5744944, 3852015, 4183372, 5157610, 5258977, 8106357,
    2508980, 2028118, 1937570, 4564692, 2811291, 5396636, 7270901, 4158088,
    1528066, 482649,  1148858, 5418153, 7814814, 169688,  2462444, 5046034,
    4213992, 4892034, 1987814, 5183169, 1736313, 235407,  5130263, 3258457,
    5801164, 1787943, 5989328, 6125690, 3482206, 4197502, 7080401, 6018354,
    7062739, 2461387, 3035980, 621164,  3901472, 7153756, 2925816, 3374250,
    1356448, 5604662, 2683270, 5601629, 4912752, 2312838, 7727142, 7921254,
    348812,  8052569, 1011223, 6026202, 4561790, 6458164, 6143691, 1744507,
    1753,    6444997, 5720892, 6924527, 2660408, 6600190, 8321269, 2772600,
    1182243, 87208,   636927,  4415111, 4423672, 6084020, 5095502, 4663471,
    8352605, 822541,  1009365, 5926272, 6400920, 1596822, 4423473, 4620952,
    6695264, 4969849, 2678278, 4611469, 4829411, 635956,  8129971, 5925040,
    4234153, 6607829, 2192938, 6653329, 2387513, 4768667, 8111961, 5199961,
    3747250, 2296099, 1239911, 4541938, 3195676, 2642980, 1254190, 8368000,
    2998219, 141835,  8291116, 2513018, 7025525, 613238,  7070156, 6161950,
    7921677, 6458423, 4040196, 4908348, 2039144, 6500539, 7561656, 6201452,
    6757063, 2105286, 6006015, 6346610, 586241,  7200804, 527981,  5637006,
    6903432, 1994046, 2491325, 6987258, 507927,  7192532, 7655613, 6545891,
    5346675, 8041997, 2647994, 3009748, 5767564, 4148469, 749577,  4357667,
    3980599, 2569011, 6764887, 1723229, 1665318, 2028038, 1163598, 5011144,
    3994671, 8368538, 7009900, 3020393, 3363542, 214880,  545376,  7609976,
    3105558, 7277073, 508145,  7826699, 860144,  3430436, 140244,  6866265,
    6195333, 3123762, 2358373, 6187330, 5365997, 6663603, 2926054, 7987710,
    8077412, 3531229, 4405932, 4606686, 1900052, 7598542, 1054478, 7648983
  };

  assign zeta = TF_TABLE[tf_case];

endmodule

// File: rtl/intt_tf_sequencer.sv
// Inverse-NTT twiddle sequencer: walks the twiddle table from k=255 down to 1 and
// streams (Q - zeta) with both butterfly addresses, one beat per butterfly.
//
// state | meaning
// IDLE  | waiting for start; counters parked
// RUN   | loading beats into the output register as downstream drains it
// FLUSH | final beat loaded, waiting for its handshake
module intt_tf_sequencer #(
  parameter int            DW = intt_pkg::DW,
  parameter logic [DW-1:0] Q  = intt_pkg::Q
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    tf_case,
  output logic [DW-1:0] tf_out,
  output logic [7:0]    addr_a,
  output logic [7:0]    addr_b,
  output logic [2:0]    stage,
  output logic          out_valid,
  input  logic          out_ready
);

  import intt_pkg::state_t;
  import intt_pkg::IDLE;
  import intt_pkg::RUN;
  import intt_pkg::FLUSH;
  import intt_pkg::N;

  state_t state, state_nxt;

  logic [2:0]    s;
  logic [7:0]    grp;
  logic [7:0]    j;
  logic [7:0]    k;
  logic [7:0]    len;
  logic [8:0]    grp_span;
  logic          j_last;
  logic          grp_last;
  logic          last_beat;
  logic          start_acc;
  logic          load_en;
  logic          flush_hs;
  logic [DW-1:0] zeta;
  logic [DW-1:0] tf_neg;

  // tf_case is the ROM read address for the beat about to be loaded, so it runs
  // one beat ahead of the registered outputs.
  assign tf_case = k;

  tf_rom u_tf_rom (
    .tf_case (tf_case),
    .zeta    (zeta)
  );

  assign tf_neg    = (zeta == '0) ? '0 : Q - zeta;
  assign len       = 8'd1 << s;
  assign grp_span  = {1'b0, grp} + {len, 1'b0};
  assign j_last    = (j == len - 8'd1);
  assign grp_last  = (grp_span == 9'(N));
  assign last_beat = (s == 3'd7) && j_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)                  state_nxt = RUN;
      RUN:     if (load_en && last_beat)   state_nxt = FLUSH;
      FLUSH:   if (out_valid && out_ready) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    start_acc = 1'b0;
    load_en   = 1'b0;
    flush_hs  = 1'b0;
    unique case (state)
      IDLE:  start_acc = start;
      RUN: begin
        busy    = 1'b1;
        load_en = !out_valid || out_ready;
      end
      FLUSH: begin
        busy     = 1'b1;
        flush_hs = out_valid && out_ready;
      end
      default: ;
    endcase
  end

  // Gentleman-Sande walk: j within a group, grp steps by 2*len, k falls per group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= 3'd0;
      grp <= 8'd0;
      j   <= 8'd0;
      k   <= 8'hFF;
    end else if (start_acc) begin
      s   <= 3'd0;
      grp <= 8'd0;
      j   <= 8'd0;
      k   <= 8'hFF;
    end else if (load_en) begin
      if (j_last) begin
        j <= 8'd0;
        k <= k - 8'd1;
        if (grp_last) begin
          grp <= 8'd0;
          s   <= s + 3'd1;
        end else begin
          grp <= grp_span[7:0];
        end
      end else begin
        j <= j + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      tf_out    <= '0;
      addr_a    <= 8'd0;
      addr_b    <= 8'd0;
      stage     <= 3'd0;
      done      <= 1'b0;
    end else begin
      done <= flush_hs;
      if (load_en) begin
        out_valid <= 1'b1;
        tf_out    <= tf_neg;
        addr_a    <= grp + j;
        addr_b    <= grp + j + len;
        stage     <= s;
      end else if (flush_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_intt_tf_sequencer.sv
// Scoreboard bench for intt_tf_sequencer: expected beats come from a modular-power
// model of the twiddle table plus hand-computed values for landmark beats.
module tb_intt_tf_sequencer;

  localparam longint QM = 64'd8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [7:0]  tf_case;
  logic [7:0]  addr_a;
  logic [7:0]  addr_b;
  logic [22:0] tf_out;
  logic [2:0]  stage;

  typedef struct {
    int          beat;
    logic [22:0] tf;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  tc;
    logic [2:0]  st;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    pop_total = 0;
  int    done_cnt = 0;
  int    cyc = 0;
  int    t0 = 0;
  bit    rand_mode = 1'b0;
  bit    hold_low = 1'b0;

  always #5 clk = ~clk;

  intt_tf_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .tf_case   (tf_case),
    .tf_out    (tf_out),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .stage     (stage),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic int brv8(input int x);
    int y = 0;
    for (int i = 0; i < 8; i++)
      if (x[i]) y = y | (1 << (7 - i));
    return y;
  endfunction

  function automatic logic [22:0] zeta_of(input int k);
    longint r = 1;
    longint b = 1753;
    int     e = brv8(k);
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * b) % QM;
      b = (b * b) % QM;
    end
    return 23'(r);
  endfunction

  function automatic int k_of(input int bt);
    int s = bt / 128;
    int r = bt % 128;
    int prev = 0;
    for (int t = 0; t < s; t++) prev += 128 >> t;
    return 255 - prev - r / (1 << s);
  endfunction

  function automatic beat_t model(input int bt);
    beat_t m;
    int s = bt / 128;
    int r = bt % 128;
    int len = 1 << s;
    int grp = (r / len) * 2 * len;
    int j = r % len;
    logic [22:0] z = zeta_of(k_of(bt));
    m.beat = bt;
    m.st   = 3'(s);
    m.a    = 8'(grp + j);
    m.b    = 8'(grp + j + len);
    m.tf   = (z == 23'd0) ? 23'd0 : 23'(QM - longint'(z));
    m.tc   = (bt == 1023) ? 8'd0 : 8'(k_of(bt + 1));
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic directed(input int bt);
    case (bt)
      0: begin
        chk("beat0_tf_out", 32'(tf_out), 32'h0B292A);
        chk("beat0_a", 32'(addr_a), 32'd0);
        chk("beat0_b", 32'(addr_b), 32'd1);
        chk("beat0_stage", 32'(stage), 32'd0);
      end
      1: begin
        chk("beat1_tf_out", 32'(tf_out), 32'h6FC8F3);
        chk("beat1_ab", {16'd0, addr_a, addr_b}, {16'd0, 8'd2, 8'd3});
      end
      128: begin
        chk("beat128_tf_out", 32'(tf_out), 32'h654186);
        chk("beat128_ab", {16'd0, addr_a, addr_b}, {16'd0, 8'd0, 8'd2});
        chk("beat128_stage", 32'(stage), 32'd1);
      end
      129: begin
        chk("beat129_tf_out", 32'(tf_out), 32'h654186);
        chk("beat129_ab", {16'd0, addr_a, addr_b}, {16'd0, 8'd1, 8'd3});
      end
      130: chk("beat130_ab", {16'd0, addr_a, addr_b}, {16'd0, 8'd4, 8'd6});
      1023: begin
        chk("beat1023_tf_out", 32'(tf_out), 32'h3681FF);
        chk("beat1023_ab", {16'd0, addr_a, addr_b}, {16'd0, 8'd127, 8'd255});
        chk("beat1023_stage", 32'(stage), 32'd7);
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rand_mode ? ($urandom_range(0, 1) != 0) : !hold_low;
  end

  // Monitor: every presented beat must equal the scoreboard head, stalled or not.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) done_cnt++;
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          chk("beat_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb[0];
          n_vec++;
          if ({tf_out, addr_a, addr_b, stage, tf_case} !== {e.tf, e.a, e.b, e.st, e.tc}) begin
            n_err++;
            $display("FAIL beat %0d: got tf_out=%h a=%0d b=%0d stage=%0d tf_case=%0d, required tf_out=%h a=%0d b=%0d stage=%0d tf_case=%0d",
                     e.beat, tf_out, addr_a, addr_b, stage, tf_case, e.tf, e.a, e.b, e.st, e.tc);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            pop_total++;
            directed(e.beat);
          end
        end
      end
    end
  end

  task automatic launch(output int base);
    for (int b = 0; b < 1024; b++) sb.push_back(model(b));
    base  = pop_total;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_low_after_start", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int base, output int lat);
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    chk("done_seen", 32'(done), 32'd1);
    lat = cyc - t0;
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("beats_per_run", 32'(pop_total - base), 32'd1024);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_pops(input int base, input int n);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (pop_total - base >= n) break;
    end
    chk("reached_beat", 32'(pop_total - base >= n), 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_tf_out", 32'(tf_out), 32'd0);
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'd0);
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_tf_case", 32'(tf_case), 32'hFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    int p;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Run 1: ready held high, full-run timing
    launch(base);
    wait_done(base, lat);
    chk("run_latency", 32'(lat), 32'd1025);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    // Run 2: 5-cycle stall at beat 300 with a start pulse inside it
    launch(base);
    wait_pops(base, 300);
    hold_low = 1'b1;
    p = pop_total;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("no_pop_during_stall", 32'(pop_total - p), 32'd0);
    hold_low = 1'b0;
    wait_done(base, lat);
    @(posedge clk);
    #1;

    // Run 3: reset at beat 500, then a fresh run
    launch(base);
    wait_pops(base, 500);
    rst = 1'b1;
    #1;
    sb.delete();
    check_reset_values();
    p = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_reset", 32'(done_cnt - p), 32'd0);
    launch(base);
    wait_done(base, lat);
    chk("run_latency_after_reset", 32'(lat), 32'd1025);

    // Runs 5-7: random ready, each start issued in the done cycle
    rand_mode = 1'b1;
    launch(base);
    for (int r = 0; r < 3; r++) begin
      wait_done(base, lat);
      if (r < 2) launch(base);
    end
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
